// File: rtl/hazard_ctrl_unit_mc.sv
// Multi-cycle hazard controller: age-ordered redirect arbitration, load-use stalls, held redirects and front-end flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
package my_pkg;
    typedef enum logic [2:0] {
        NEXT_PC        = 3'd0,
        BRANCH_ALU     = 3'd1,
        BRANCH_PC_JUMP = 3'd2,
        TRAP_ILLEGAL   = 3'd3,
        XEPC           = 3'd4
    } PCSrc_Enum;
endpackage

module hazard_ctrl_unit_mc #(
    parameter int REG_ADDR_W       = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int FLUSH_STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_jump_i,
    input  logic                  mem_branch_i,
    input  logic                  mem_branch_taken_i,
    input  logic                  mem_addtopc_i,
    input  logic                  ex_mret_i,
    input  logic                  de_trap_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [REG_ADDR_W-1:0] de_rs1_i,
    input  logic [REG_ADDR_W-1:0] de_rs2_i,
    input  logic                  de_rs1_used_i,
    input  logic                  de_rs2_used_i,
    input  logic                  fetch_ready_i,
    output my_pkg::PCSrc_Enum     pc_src_o,
    output logic                  en_pc_o,
    output logic                  en_ifid_o,
    output logic                  ifid_flush_o,
    output logic                  ctrl_mux_de_o,
    output logic                  ctrl_mux_ex_o,
    output logic                  busy_o,
    output logic [31:0]           perf_stall_cnt_o,
    output logic [31:0]           perf_flush_cnt_o
);
    import my_pkg::*;

    typedef enum logic [1:0] {S_IDLE, S_LOAD_STALL, S_REDIR_PEND, S_FLUSH} state_e;

    // Counters hold the number of extra cycles still to spend after the current one.
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_STAGES - 2);
    localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_BUBBLES - 2);

    state_e    state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    PCSrc_Enum pend_src_q, pend_src_d;
    logic      stall_cyc_s;
    logic      br_s, redir_s, hazard_s;
    PCSrc_Enum tgt_s;

    assign br_s     = mem_jump_i | (mem_branch_i & mem_branch_taken_i);
    assign redir_s  = br_s | ex_mret_i | de_trap_i;
    assign tgt_s    = br_s ? (mem_addtopc_i ? BRANCH_ALU : BRANCH_PC_JUMP)
                           : (ex_mret_i ? XEPC : TRAP_ILLEGAL);
    assign hazard_s = ex_memread_i && (ex_rd_i != '0) &&
                      ((de_rs1_used_i && (ex_rd_i == de_rs1_i)) ||
                       (de_rs2_used_i && (ex_rd_i == de_rs2_i)));

    // Next-state and Mealy output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_src_d    = pend_src_q;
        stall_cyc_s   = 1'b0;
        pc_src_o      = NEXT_PC;
        en_pc_o       = fetch_ready_i;
        en_ifid_o     = fetch_ready_i;
        ifid_flush_o  = 1'b0;
        ctrl_mux_de_o = 1'b1;
        ctrl_mux_ex_o = 1'b1;
        busy_o        = (state_q != S_IDLE);
        case (state_q)
            S_IDLE, S_LOAD_STALL: begin
                if (redir_s) begin
                    ifid_flush_o  = 1'b1;
                    en_ifid_o     = 1'b1;
                    ctrl_mux_de_o = 1'b0;
                    ctrl_mux_ex_o = ~br_s;
                    if (fetch_ready_i) begin
                        en_pc_o  = 1'b1;
                        pc_src_o = tgt_s;
                        if (FLUSH_STAGES > 1) begin
                            state_d = S_FLUSH;
                            cnt_d   = FLUSH_INIT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        en_pc_o    = 1'b0;
                        pend_src_d = tgt_s;
                        state_d    = S_REDIR_PEND;
                    end
                end else if ((state_q == S_LOAD_STALL) || hazard_s) begin
                    stall_cyc_s   = 1'b1;
                    en_pc_o       = 1'b0;
                    en_ifid_o     = 1'b0;
                    ctrl_mux_de_o = 1'b0;
                    if (state_q == S_LOAD_STALL) begin
                        if (cnt_q == 2'd0) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q - 2'd1;
                        end
                    end else if (LOAD_USE_BUBBLES > 1) begin
                        state_d = S_LOAD_STALL;
                        cnt_d   = STALL_INIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIR_PEND: begin
                ifid_flush_o  = 1'b1;
                en_ifid_o     = 1'b1;
                ctrl_mux_de_o = 1'b0;
                pc_src_o      = pend_src_q;
                if (fetch_ready_i) begin
                    if (FLUSH_STAGES > 1) begin
                        state_d = S_FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_REDIR_PEND;
                end
            end
            S_FLUSH: begin
                ifid_flush_o  = 1'b1;
                en_ifid_o     = 1'b1;
                ctrl_mux_de_o = 1'b0;
                if (cnt_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Reset dominates every output, independent of state.
        if (!rst_n) begin
            stall_cyc_s   = 1'b0;
            pc_src_o      = NEXT_PC;
            en_pc_o       = 1'b0;
            en_ifid_o     = 1'b0;
            ifid_flush_o  = 1'b1;
            ctrl_mux_de_o = 1'b0;
            ctrl_mux_ex_o = 1'b0;
            busy_o        = 1'b0;
        end else begin
            busy_o = (state_q != S_IDLE);
        end
    end

    // State, counter and pending-target registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            pend_src_q <= NEXT_PC;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_src_q <= pend_src_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_cyc_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_flush_cnt_o = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl_unit_mc.md
# hazard_ctrl_unit_mc

Parametrised, multi-cycle successor to the single-cycle hazard controller of the RISCV-Lite pipeline. Arbitrates redirects (branch/jump from MEM, MRET from EX, illegal-instruction trap from DE) by instruction age and detects load-use hazards with a configurable bubble count. Adds sequential behaviour: redirects are held while the fetch FSM is stalled, and a configurable number of front-end slots is flushed after each redirect. Drives the PC mux, PC/IF-ID enables and the DE/EX nop muxes.

## Interface
- REG_ADDR_W, 5, register index width (4 for RV32E)
- LOAD_USE_BUBBLES, 1, stall cycles per load-use hazard (1..3)
- FLUSH_STAGES, 1, IF/ID flush cycles per redirect, including the redirect cycle (1..4)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- mem_jump_i  in  1  jump in MEM
- mem_branch_i  in  1  branch in MEM
- mem_branch_taken_i  in  1  branch condition true
- mem_addtopc_i  in  1  1: target branch_alu, 0: branch_pc_jump
- ex_mret_i  in  1  MRET in EX
- de_trap_i  in  1  illegal instruction in DE
- ex_memread_i  in  1  load in EX
- ex_rd_i  in  REG_ADDR_W  load destination
- de_rs1_i, de_rs2_i  in  REG_ADDR_W  DE sources
- de_rs1_used_i, de_rs2_used_i  in  1  source actually read
- fetch_ready_i  in  1  fetch FSM can accept a new PC
- pc_src_o  out  PCSrc_Enum (my_pkg)  next_pc, branch_alu, branch_pc_jump, trap_illegal, xepc
- en_pc_o  out  1  load PC
- en_ifid_o  out  1  load IF/ID (0 = hold)
- ifid_flush_o  out  1  load nop into IF/ID (overrides en_ifid_o)
- ctrl_mux_de_o  out  1  0 = nop into EX next cycle
- ctrl_mux_ex_o  out  1  0 = nop into MEM next cycle
- busy_o  out  1  FSM not in IDLE
- perf_stall_cnt_o, perf_flush_cnt_o  out  32  performance counters (see Configuration)

## Operation
- States: IDLE, LOAD_STALL, REDIR_PEND, FLUSH. Outputs are Mealy (combinational from state and inputs).
- Redirect = (mem_jump_i | mem_branch_i & mem_branch_taken_i) | ex_mret_i | de_trap_i. Priority is oldest first: branch/jump > MRET > trap. Target is branch_alu/branch_pc_jump per mem_addtopc_i, xepc, or trap_illegal.
- Squash per source: branch/jump gives ex=0, de=0, flush=1. MRET and trap give ex=1, de=0, flush=1.
- Redirect in IDLE or LOAD_STALL:
  - If fetch_ready_i=1: en_pc=1, pc_src=target. Go to FLUSH if FLUSH_STAGES>1, otherwise IDLE.
  - If fetch_ready_i=0: en_pc=0, latch target into pend_src, go to REDIR_PEND.
  - A redirect aborts LOAD_STALL.
- REDIR_PEND: ex=1, de=0, flush=1, en_pc=fetch_ready_i, pc_src=pend_src. When fetch_ready_i=1, exit as above. All other inputs are ignored.
- FLUSH: counter runs FLUSH_STAGES-1 cycles. flush=1, de=0, ex=1, en_pc=fetch_ready_i, pc_src=next_pc. Returns to IDLE when the count expires. Inputs are ignored.
- Load-use hazard (IDLE, no redirect): ex_memread_i & ex_rd_i≠0 & ((de_rs1_used_i & rd==rs1) | (de_rs2_used_i & rd==rs2)).
  - Outputs: en_pc=0, en_ifid=0, de=0, ex=1, pc_src=next_pc.
  - If LOAD_USE_BUBBLES>1, go to LOAD_STALL for LOAD_USE_BUBBLES-1 further cycles with the same outputs, then IDLE.
- Normal: ex=1, de=1, flush=0, en_pc=en_ifid=fetch_ready_i, pc_src=next_pc.
- Reset (rst_n=0 at an edge): state IDLE, counters 0, pend_src=next_pc. While rst_n=0, outputs are en_pc=0, en_ifid=0, flush=1, de=0, ex=0, pc_src=next_pc, busy=0.

## Timing
- Zero-cycle decision: outputs reflect the same-cycle inputs. State updates on the rising clk edge.
- A redirect with fetch ready occupies exactly FLUSH_STAGES cycles of flush=1.
- A redirect pending N cycles adds N cycles. The PC loads in the first cycle with fetch_ready_i=1.
- A load-use hazard occupies exactly LOAD_USE_BUBBLES cycles with en_pc=0.
- Simultaneous branch+MRET+trap: only the branch is taken and only the branch squash pattern is used. MRET and trap are squashed, not queued.
- Reset mid-FLUSH, mid-PEND or mid-LOAD_STALL: the next cycle is IDLE, and pend_src is lost.

## Configuration
- HAZARD_PERF_CNT_EN defined: two 32-bit saturating counters, reset to 0.
  - perf_stall_cnt_o increments on each load-use stall cycle.
  - perf_flush_cnt_o increments on each cycle with flush=1 outside reset.
- HAZARD_PERF_CNT_EN undefined: counters are not built and both ports are tied to 0.

## Test plan
- Defaults, load x5 in EX, DE rs2=x5 used → one cycle en_pc=0, en_ifid=0, de=0, ex=1, then normal. With rd=x0 → no stall.
- LOAD_USE_BUBBLES=3 with the same hazard → en_pc=0 for exactly 3 cycles, busy_o=1 for cycles 2–3.
- Taken branch (addtopc=1), FLUSH_STAGES=3, fetch ready → cycle 0: pc_src=branch_alu, en_pc=1, ex=0, de=0, flush=1. Cycles 1–2: flush=1, pc_src=next_pc. Cycle 3: normal.
- Trap with fetch_ready_i=0 for 2 cycles → en_pc=0 for 2 cycles, then en_pc=1 with pc_src=trap_illegal. Squash is ex=1, de=0.
- Jump, MRET and trap in the same cycle → pc_src=branch_pc_jump, ex=0.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 1 redirect at FLUSH_STAGES=2 → stall_cnt=2, flush_cnt=2. rst_n low mid-FLUSH → both counters 0 and next cycle IDLE.
